// File: rtl/vector_sequencer.sv
// Multi-cycle vector instruction sequencer: stalls fetch/decode and walks N_ELEM lane elements.
// Optional memory-wait abort is enabled by defining VSEQ_TIMEOUT_EN.
module vector_sequencer #(
    parameter int N_ELEM  = 4,
    parameter int IDX_W   = 2,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic [IDX_W-1:0] elem_idx,
    output logic             elem_valid,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ALU  = 2'd1,
        MEM  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [4:0]       OP_VLD   = 5'b10100;
    localparam logic [4:0]       OP_VST   = 5'b10101;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [4:0]       op_q;
    logic             isMemOp;

    assign isMemOp = (op == OP_VLD) || (op == OP_VST);

`ifdef VSEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] waitCnt_q;
    logic             errFlag_q;
`endif

    // Outputs decode from registered state, so an async reset drops them at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            op_q      <= '0;
`ifdef VSEQ_TIMEOUT_EN
            waitCnt_q <= '0;
            errFlag_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        idx_q   <= '0;
                        state_q <= isMemOp ? MEM : ALU;
                    end
`ifdef VSEQ_TIMEOUT_EN
                    waitCnt_q <= '0;
                    errFlag_q <= 1'b0;
`endif
                end
                ALU: begin
                    if (idx_q == LAST_IDX) begin
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                MEM: begin
                    if (mem_ready) begin
`ifdef VSEQ_TIMEOUT_EN
                        waitCnt_q <= '0;
`endif
                        if (idx_q == LAST_IDX) begin
                            state_q <= DONE;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
`ifdef VSEQ_TIMEOUT_EN
                    // The abort cycle itself counts as the last of TIMEOUT not-ready cycles.
                    else if (waitCnt_q == CNT_W'(TIMEOUT - 1)) begin
                        waitCnt_q <= '0;
                        errFlag_q <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        waitCnt_q <= waitCnt_q + 1'b1;
                    end
`endif
                end
                DONE: begin
                    idx_q   <= '0;
                    state_q <= IDLE;
`ifdef VSEQ_TIMEOUT_EN
                    waitCnt_q <= '0;
                    errFlag_q <= 1'b0;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = (state_q != IDLE);
    assign stall      = busy | start;
    assign mem_req    = (state_q == MEM);
    assign mem_we     = mem_req & (op_q == OP_VST);
    assign elem_idx   = idx_q;
    assign elem_valid = (state_q == ALU) | ((state_q == MEM) & mem_ready);
    assign done       = (state_q == DONE);

`ifdef VSEQ_TIMEOUT_EN
    assign err = (state_q == DONE) & errFlag_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/vector_sequencer.md
# vector_sequencer

Multi-cycle controller for vector instructions (opcodes `5'b1xxxx`) in the processor's execute stage. When the main decoder flags an instruction as vectorial, this block stalls fetch/decode and steps the lane datapath through `N_ELEM` elements, one element per cycle. For vector load/store it runs a request/ready handshake with data memory per element. It raises a one-cycle `done` pulse when the instruction has retired.

## Interface
Parameters:
- `N_ELEM`, 4: elements per vector instruction (≥2).
- `IDX_W`, 2: element index width; `2**IDX_W ≥ N_ELEM`.
- `TIMEOUT`, 16: memory-wait limit in cycles. Used only with `VSEQ_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: decoder `vectorial` flag for the instruction in decode.
- `op` in 5: opcode of that instruction. Sampled when `start` is accepted.
- `mem_ready` in 1: memory accepted/completed the current element access.
- `mem_req` out 1: memory access request for the current element.
- `mem_we` out 1: 1 = store, 0 = load. Valid while `mem_req` = 1.
- `elem_idx` out `IDX_W`: index of the element being processed.
- `elem_valid` out 1: commit strobe for element `elem_idx` (lane register write).
- `stall` out 1: freezes PC and IF/ID registers.
- `busy` out 1: sequencer not in IDLE.
- `done` out 1: one-cycle retire pulse.
- `err` out 1: memory timeout abort flag.

## Operation
Opcode classes, decided by `op`:
- `5'b10100` is VLD. `5'b10101` is VST. Both are memory class.
- Every other opcode arriving with `start` is ALU class.

FSM states: IDLE, ALU, MEM, DONE.

IDLE
- `start` = 1 latches `op` and sets `idx` to 0.
- Next state is MEM for memory class, ALU otherwise.

ALU
- `elem_valid` = 1 every cycle.
- `idx` increments each cycle.
- After the cycle with `idx` = `N_ELEM-1`, go to DONE.

MEM
- `mem_req` = 1 continuously. `mem_we` = (latched op == VST).
- `elem_idx` stays stable until `mem_ready` = 1.
- In a cycle with `mem_ready` = 1: `elem_valid` = 1 and `idx` increments.
- On the ready cycle for `idx` = `N_ELEM-1`, go to DONE.

DONE
- `done` = 1 for exactly one cycle, then return to IDLE.

Output rules:
- `stall` = (state ≠ IDLE) | (state == IDLE & `start`). This is a combinational path from `start`, so the vector instruction is held in decode from its first cycle.
- `stall` is still 1 in DONE. It drops in the following IDLE cycle, and that is when the pipeline advances past the instruction.
- `busy` = (state ≠ IDLE).
- `start` is ignored in every state except IDLE.
- `idx` never wraps past `N_ELEM-1`. It returns to 0 in DONE.

## Timing
- Reset: state IDLE, `idx` = 0, latched op = 0, timeout counter = 0.
- Every output is 0 during reset. `stall` is 0 provided `start` = 0.
- An `rst_n` assertion mid-instruction aborts it immediately: no `done`, no `err`, outputs go low asynchronously.
- ALU-class latency:
  - `start` accepted in cycle 0.
  - `elem_valid` in cycles 1..`N_ELEM`.
  - `done` in cycle `N_ELEM+1`.
  - Back in IDLE in cycle `N_ELEM+2`.
- MEM class: same cycle count when `mem_ready` is held at 1. Each cycle of `mem_ready` = 0 adds one cycle.
- `elem_valid` is never asserted while `mem_req` = 1 and `mem_ready` = 0.
- Back-to-back instructions: a new `start` is accepted in the IDLE cycle that follows DONE.

## Configuration
- `VSEQ_TIMEOUT_EN` defined:
  - A counter runs in MEM. It clears on each `mem_ready`.
  - When it reaches `TIMEOUT` consecutive not-ready cycles, the FSM goes to DONE with `err` = 1 alongside `done`. That element gets no `elem_valid`.
  - `err` is a one-cycle pulse, like `done`.
- `VSEQ_TIMEOUT_EN` not defined:
  - No counter exists and `err` is tied to 0.
  - MEM waits indefinitely for `mem_ready`.

## Test plan
- ALU op `5'b10000`, `N_ELEM`=4, pulse `start` → `elem_valid` in cycles 1–4 with `elem_idx` 0,1,2,3; `done` in cycle 5; `stall` high in cycles 0–5 and low in cycle 6.
- VST `5'b10101`, `mem_ready` low for 2 cycles on element 1 → `mem_req`/`mem_we` = 1 throughout; `elem_idx` holds at 1 for 3 cycles; `done` in cycle 7.
- VLD with `start` re-asserted mid-sequence → extra `start` ignored, `mem_we` = 0, exactly 4 `elem_valid` pulses, one `done`.
- `rst_n` driven low in the cycle with `elem_idx`=2 → all outputs 0 immediately; after release state is IDLE and `idx` = 0; no `done`.
- With `VSEQ_TIMEOUT_EN`, `TIMEOUT`=16, `mem_ready` stuck at 0 → `done` and `err` together 16 cycles after MEM entry, then IDLE. Without the macro: still busy at cycle 100 and `err` = 0.
